// File: rtl/memory_access.sv
// memory_access: E->M pipeline register plus load/store memory handshake with lane alignment and extension.
module memory_access (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] ALUResultE,
  input  logic [63:0] WriteDataE,
  input  logic [63:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [2:0]  Funct3E,
  input  logic [1:0]  ResultSrcE,
  input  logic        FlushM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] ALUResultM,
  output logic [63:0] ReadDataM,
  output logic [63:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic        StallM,
  output logic        MisalignM
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nextState;
  logic [63:0] writeDataM, loadData, shifted;
  logic        regWriteR, memReadM, memWriteM, memOp, misaligned;
  logic [2:0]  funct3M, off;
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ALUResultM <= '0;
      writeDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      regWriteR  <= 1'b0;
      memReadM   <= 1'b0;
      memWriteM  <= 1'b0;
      funct3M    <= '0;
      ResultSrcM <= '0;
      loadData   <= '0;
    end else begin
      state <= nextState;
      if (!StallM) begin
        ALUResultM <= FlushM ? '0 : ALUResultE;
        writeDataM <= FlushM ? '0 : WriteDataE;
        PCPlus4M   <= FlushM ? '0 : PCPlus4E;
        RdM        <= FlushM ? '0 : RdE;
        regWriteR  <= FlushM ? 1'b0 : RegWriteE;
        memReadM   <= FlushM ? 1'b0 : MemReadE;
        memWriteM  <= FlushM ? 1'b0 : MemWriteE;
        funct3M    <= FlushM ? '0 : Funct3E;
        ResultSrcM <= FlushM ? '0 : ResultSrcE;
      end
      if (dmem_req && dmem_ready && !dmem_we) loadData <= dmem_rdata;
    end
  end
  always_comb begin
    off        = ALUResultM[2:0];
    memOp      = memReadM | memWriteM;
    misaligned = funct3M[1:0] == 2'd1 ? off[0] :
                 funct3M[1:0] == 2'd2 ? |off[1:0] :
                 funct3M[1:0] == 2'd3 ? |off : 1'b0;
    MisalignM  = memOp & misaligned;
    RegWriteM  = regWriteR & ~MisalignM;
    nextState  = state;
    dmem_req   = 1'b0;
    case (state)
      IDLE: if (memOp && !misaligned) begin
        dmem_req  = 1'b1;
        nextState = dmem_ready ? DONE : WAIT;
      end
      WAIT: begin
        dmem_req  = 1'b1;
        nextState = dmem_ready ? DONE : WAIT;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
    StallM     = dmem_req;
    dmem_we    = memWriteM;
    dmem_addr  = {ALUResultM[63:3], 3'b000};
    dmem_wdata = writeDataM << {off, 3'b000};
    dmem_be    = !memWriteM ? 8'h00 :
                 funct3M[1:0] == 2'd0 ? 8'h01 << off :
                 funct3M[1:0] == 2'd1 ? 8'h03 << off :
                 funct3M[1:0] == 2'd2 ? 8'h0F << off : 8'hFF;
    shifted    = loadData >> {off, 3'b000};
    ReadDataM  = !memReadM ? '0 :
                 funct3M == 3'b000 ? {{56{shifted[7]}}, shifted[7:0]} :
                 funct3M == 3'b001 ? {{48{shifted[15]}}, shifted[15:0]} :
                 funct3M == 3'b010 ? {{32{shifted[31]}}, shifted[31:0]} :
                 funct3M == 3'b011 ? shifted :
                 funct3M == 3'b100 ? {56'd0, shifted[7:0]} :
                 funct3M == 3'b101 ? {48'd0, shifted[15:0]} :
                 funct3M == 3'b110 ? {32'd0, shifted[31:0]} : '0;
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed-vector bench for memory_access with hand-computed expectations.
module tb_memory_access;
  logic        clock, reset;
  logic [63:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemReadE, MemWriteE, FlushM;
  logic [2:0]  Funct3E;
  logic [1:0]  ResultSrcE;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic [63:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, StallM, MisalignM;
  logic [1:0]  ResultSrcM;
  int total = 0, bad = 0;
  memory_access dut (
    .clock(clock), .reset(reset),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .Funct3E(Funct3E), .ResultSrcE(ResultSrcE), .FlushM(FlushM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .StallM(StallM), .MisalignM(MisalignM)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic setE(input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                      input logic [1:0] rs);
    ALUResultE = a; WriteDataE = wd; PCPlus4E = a + 64'd4; RdE = rd;
    RegWriteE = rw; MemReadE = mr; MemWriteE = mw; Funct3E = f3; ResultSrcE = rs;
  endtask
  task automatic doLoad(input string tag, input logic [63:0] a, input logic [2:0] f3,
                        input logic [63:0] rdata, input logic [63:0] exp);
    setE(a, 64'd0, 5'd1, 1'b1, 1'b1, 1'b0, f3, 2'd1);
    tick;
    setE(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    dmem_ready = 1'b1; dmem_rdata = rdata;
    #1;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_addr"}, dmem_addr, {a[63:3], 3'b000});
    tick;
    dmem_ready = 1'b0; dmem_rdata = 64'd0;
    #1;
    chk({tag, "_stall_done"}, StallM, 0);
    chk({tag, "_data"}, ReadDataM, exp);
    tick;
  endtask
  task automatic doStore(input string tag, input logic [63:0] a, input logic [2:0] f3,
                         input logic [63:0] wd, input logic [7:0] be, input logic [63:0] wdata);
    setE(a, wd, 5'd0, 1'b0, 1'b0, 1'b1, f3, 2'd0);
    tick;
    setE(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    dmem_ready = 1'b1;
    #1;
    chk({tag, "_be"}, dmem_be, be);
    chk({tag, "_wdata"}, dmem_wdata, wdata);
    chk({tag, "_we"}, dmem_we, 1);
    tick;
    dmem_ready = 1'b0;
    #1;
    chk({tag, "_done"}, StallM, 0);
    tick;
  endtask
  initial begin
    reset = 1'b1; FlushM = 1'b0; dmem_ready = 1'b0; dmem_rdata = 64'd0;
    setE(64'h5, 64'h7, 5'd3, 1'b1, 1'b1, 1'b0, 3'd3, 2'd2);
    tick;
    tick;
    chk("rst_alu", ALUResultM, 0);
    chk("rst_rd", RdM, 0);
    chk("rst_regwrite", RegWriteM, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_readdata", ReadDataM, 0);
    chk("rst_pc", PCPlus4M, 0);
    chk("rst_src", ResultSrcM, 0);
    reset = 1'b0;
    setE(64'h10, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    tick;
    chk("alu_result", ALUResultM, 64'h10);
    chk("alu_rd", RdM, 5);
    chk("alu_regwrite", RegWriteM, 1);
    chk("alu_pc", PCPlus4M, 64'h14);
    chk("alu_stall", StallM, 0);
    chk("alu_req", dmem_req, 0);
    setE(64'h1003, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1);
    dmem_rdata = 64'h0000_0000_8000_0000;
    tick;
    setE(64'h2006, 64'hABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd0);
    #1;
    chk("lb_stall1", StallM, 1);
    chk("lb_req", dmem_req, 1);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_we", dmem_we, 0);
    tick;
    chk("lb_stall2", StallM, 1);
    chk("lb_hold", ALUResultM, 64'h1003);
    tick;
    chk("lb_stall3", StallM, 1);
    tick;
    dmem_ready = 1'b1;
    #1;
    chk("lb_stall4", StallM, 1);
    tick;
    dmem_ready = 1'b0; dmem_rdata = 64'd0;
    #1;
    chk("lb_done_stall", StallM, 0);
    chk("lb_done_req", dmem_req, 0);
    chk("lb_data", ReadDataM, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_rd", RdM, 7);
    chk("lb_regwrite", RegWriteM, 1);
    chk("lb_src", ResultSrcM, 1);
    tick;
    setE(64'h3002, 64'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd2, 2'd1);
    dmem_ready = 1'b1;
    #1;
    chk("sh_be", dmem_be, 8'hC0);
    chk("sh_wdata", dmem_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we", dmem_we, 1);
    chk("sh_addr", dmem_addr, 64'h2000);
    chk("sh_req", dmem_req, 1);
    chk("sh_readdata", ReadDataM, 0);
    tick;
    dmem_ready = 1'b0;
    #1;
    chk("sh_done_stall", StallM, 0);
    chk("sh_done_req", dmem_req, 0);
    tick;
    setE(64'h40, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    #1;
    chk("lw_misalign", MisalignM, 1);
    chk("lw_req", dmem_req, 0);
    chk("lw_regwrite", RegWriteM, 0);
    chk("lw_stall", StallM, 0);
    chk("lw_rd", RdM, 9);
    FlushM = 1'b1;
    tick;
    FlushM = 1'b0;
    chk("flush_regwrite", RegWriteM, 0);
    chk("flush_rd", RdM, 0);
    chk("flush_alu", ALUResultM, 0);
    chk("flush_misalign", MisalignM, 0);
    setE(64'h4000, 64'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'd3, 2'd1);
    tick;
    setE(64'h50, 64'd0, 5'd13, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    FlushM = 1'b1;
    #1;
    chk("stflush_stall", StallM, 1);
    tick;
    chk("stflush_rd", RdM, 12);
    chk("stflush_regwrite", RegWriteM, 1);
    chk("stflush_alu", ALUResultM, 64'h4000);
    chk("stflush_stall2", StallM, 1);
    FlushM = 1'b0; reset = 1'b1;
    setE(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    tick;
    reset = 1'b0; dmem_ready = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("rstwait_req", dmem_req, 0);
    chk("rstwait_stall", StallM, 0);
    chk("rstwait_rd", RdM, 0);
    chk("rstwait_regwrite", RegWriteM, 0);
    chk("rstwait_alu", ALUResultM, 0);
    chk("rstwait_addr", dmem_addr, 0);
    tick;
    dmem_ready = 1'b0; dmem_rdata = 64'd0;
    #1;
    chk("rstwait_idle", dmem_req, 0);
    doLoad("lbu", 64'h5001, 3'b100, 64'h0000_0000_0000_F200, 64'h0000_0000_0000_00F2);
    doLoad("lhu", 64'h6004, 3'b101, 64'h0000_8765_0000_0000, 64'h0000_0000_0000_8765);
    doLoad("lw", 64'h7004, 3'b010, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
    doLoad("ld", 64'h7008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    doLoad("lh", 64'h7002, 3'b001, 64'h0000_0000_9ABC_0000, 64'hFFFF_FFFF_FFFF_9ABC);
    doLoad("f3_111", 64'hB000, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    doStore("sb", 64'h8005, 3'b000, 64'h5A, 8'h20, 64'h0000_5A00_0000_0000);
    doStore("sw", 64'hA004, 3'b010, 64'hDEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    doStore("sd", 64'h9000, 3'b011, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high, with ports named clock and reset.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- ALUResultE  in  64  address or ALU result from execute
- WriteDataE  in  64  store data (rs2)
- PCPlus4E  in  64  PC+4 from execute
- RdE  in  5  destination register
- RegWriteE  in  1  register write enable
- MemReadE  in  1  load instruction
- MemWriteE  in  1  store instruction
- Funct3E  in  3  access size and signedness
- ResultSrcE  in  2  result select, passed through
- FlushM  in  1  load a bubble instead of the execute values
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  64  doubleword-aligned address
- dmem_wdata  out  64  lane-aligned store data
- dmem_be  out  8  byte enables
- dmem_ready  in  1  memory accepts or completes the request
- dmem_rdata  in  64  doubleword read data
- ALUResultM  out  64  registered ALU result
- ReadDataM  out  64  extended load data
- PCPlus4M  out  64  registered PC+4
- RdM  out  5  registered destination register
- RegWriteM  out  1  write enable toward write-back
- ResultSrcM  out  2  registered result select
- StallM  out  1  hold the upstream stages
- MisalignM  out  1  misaligned access detected

Function
REQ-004 The E->M register SHALL load all E inputs on a rising clock edge when StallM=0; when StallM=1 it SHALL hold its contents.
REQ-005 When FlushM=1 and StallM=0, the register SHALL load a bubble: RegWrite, MemRead, MemWrite = 0, all other fields 0. If StallM=1, the stall SHALL take priority and FlushM SHALL be ignored.
REQ-006 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-007 In IDLE with an aligned memory op (MemRead or MemWrite) in M:
- dmem_req=1 and StallM=1
- if dmem_ready=1, next state is DONE; otherwise next state is WAIT.
REQ-008 In IDLE with a non-memory op or a misaligned op: dmem_req=0, StallM=0, and the state stays IDLE.
REQ-009 In WAIT: dmem_req=1 and StallM=1; on dmem_ready=1 the next state is DONE; otherwise it stays WAIT.
REQ-010 In DONE: dmem_req=0 and StallM=0; the next state is IDLE.
REQ-011 Minimum M-stage occupancy SHALL be 2 cycles for a memory op and 1 cycle for any other op.
REQ-012 dmem_rdata SHALL be captured into the load-data register on the cycle dmem_req=1 and dmem_ready=1 with dmem_we=0; dmem_ready SHALL be ignored when dmem_req=0.
REQ-013 dmem_addr SHALL be {ALUResultM[63:3], 3'b000}, and dmem_we SHALL equal MemWriteM.
REQ-014 Let off = ALUResultM[2:0]. Loads SHALL extract from byte lane off:
- 000 LB: sign-extend 8 bits
- 001 LH: sign-extend 16 bits
- 010 LW: sign-extend 32 bits
- 011 LD: full 64 bits
- 100 LBU: zero-extend 8 bits
- 101 LHU: zero-extend 16 bits
- 110 LWU: zero-extend 32 bits
- 111: result 0
REQ-015 Stores SHALL drive dmem_wdata = WriteData shifted left by off*8 and dmem_be as follows:
- SB: 1<<off
- SH: 8'h03<<off
- SW: 8'h0F<<off
- SD: 8'hFF
REQ-016 Alignment rules:
- halfword access is misaligned if off[0]=1
- word access is misaligned if off[1:0]!=0
- doubleword access is misaligned if off!=0
- byte access is never misaligned
REQ-017 On a misaligned access: MisalignM=1 while the op is in M, no request is issued, RegWriteM is forced to 0, and StallM=0.
REQ-018 ReadDataM SHALL be the extended load-data register; it SHALL be 0 for non-load ops.
REQ-019 ALUResultM, PCPlus4M, RdM and ResultSrcM SHALL be driven directly from the E->M register.

Reset
REQ-020 On reset:
- all E->M register fields and the load-data register SHALL be 0
- the state SHALL be IDLE
- all outputs SHALL be 0
REQ-021 A reset asserted in WAIT or DONE SHALL abandon the access; dmem_req SHALL be 0 from the cycle after the reset edge, and a late dmem_ready SHALL be ignored.

Verification
REQ-022 Non-memory op ALUResultE=64'h10, RdE=5, RegWriteE=1 -> one cycle later: ALUResultM=64'h10, RdM=5, RegWriteM=1, StallM never asserted.
REQ-023 LB at address 0x1003, dmem_rdata=64'h00000000_80000000, dmem_ready after 3 wait cycles -> StallM high for 4 cycles; in DONE, ReadDataM=64'hFFFF_FFFF_FFFF_FF80; dmem_addr=0x1000.
REQ-024 SH at address 0x2006 with WriteDataE=64'hABCD -> dmem_be=8'hC0, dmem_wdata=64'hABCD_0000_0000_0000, dmem_we=1, dmem_ready same cycle -> DONE next cycle.
REQ-025 LW at address 0x3002 -> MisalignM=1, dmem_req=0, RegWriteM=0, StallM=0.
REQ-026 Reset asserted in WAIT, then dmem_ready pulsed -> state IDLE, dmem_req=0, all outputs 0.
REQ-027 FlushM=1 during a stall -> register holds; FlushM=1 with no stall -> RegWriteM=0, RdM=0 next cycle.
